// File: rtl/cpu_run_pkg.sv
// Shared types and speed codes for the board-level CPU run controller.
// Optional cycle counter is enabled by defining CPU_RUN_CYCLE_COUNTER_EN.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } run_state_e;

    localparam logic [1:0] SPD_FULL = 2'd0;
    localparam logic [1:0] SPD_DIV1 = 2'd1;
    localparam logic [1:0] SPD_DIV2 = 2'd2;
    localparam logic [1:0] SPD_DIV3 = 2'd3;

    function automatic logic [31:0] spd_div(
        input logic [1:0]  spd,
        input logic [31:0] d1,
        input logic [31:0] d2,
        input logic [31:0] d3
    );
        logic [31:0] d;
        d = 32'd1;
        unique case (spd)
            SPD_DIV1: d = d1;
            SPD_DIV2: d = d2;
            SPD_DIV3: d = d3;
            default:  d = 32'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_key_debounce.sv
// Key conditioner: 2-FF synchroniser, level debounce and press pulse.
// Released level (1) is the reset state; press = accepted 1->0 edge.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam logic [31:0] LAST = 32'(DEB_CYCLES - 1);

    logic        s1;
    logic        s2;
    logic        level;
    logic [31:0] cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_n;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= s2;
                press <= ~s2;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step clock-enable controller with speed prescaler and LED probe.
// Define CPU_RUN_CYCLE_COUNTER_EN to build the cpu_ce pulse counter.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned DEB_CYCLES   = 500_000,
    parameter int unsigned DIV1         = 5_000,
    parameter int unsigned DIV2         = 500_000,
    parameter int unsigned DIV3         = 5_000_000,
    parameter int unsigned HB_DIV       = 25_000_000,
    parameter int unsigned N_CH         = 4,
    parameter int unsigned LED_W        = 18,
    parameter int unsigned RUN_AT_RESET = 1,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              key_run_n,
    input  logic              key_step_n,
    input  logic [1:0]        sw_speed,
    input  logic [CH_W-1:0]   sw_ch,
    input  logic [N_CH*32-1:0] probe_i,
    output logic              cpu_ce,
    output logic              cpu_rst_n,
    output logic              halted,
    output logic              heartbeat,
    output logic [31:0]       cycle_cnt,
    output logic [LED_W-1:0]  led_o
);

    localparam run_state_e RST_ST = (RUN_AT_RESET != 0) ? RUN : HALT;

    // Bits [1:0] synchronise the release; [3:2] hold off cpu_ce two more cycles.
    logic [3:0] rst_pipe;
    logic       ce_ok;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[2:0], 1'b1};
    end

    assign cpu_rst_n = rst_pipe[1];
    assign ce_ok     = rst_pipe[3];

    logic run_press;
    logic step_press;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_run (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (key_run_n),
        .press    (run_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_step (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .key_n    (key_step_n),
        .press    (step_press)
    );

    run_state_e state;
    run_state_e state_nx;

    always_comb begin
        state_nx = state;
        unique case (state)
            HALT: begin
                if (run_press)       state_nx = RUN;
                else if (step_press) state_nx = STEP;
            end
            RUN:  if (run_press) state_nx = HALT;
            STEP: state_nx = HALT;
            default: state_nx = HALT;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state <= RST_ST;
        else        state <= state_nx;
    end

    logic [1:0]  spd_s1;
    logic [1:0]  spd_s2;
    logic [1:0]  spd_q;
    logic        spd_chg;
    logic [31:0] div;
    logic [31:0] pre_cnt;
    logic        at_top;
    logic        tick;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            spd_s1 <= SPD_FULL;
            spd_s2 <= SPD_FULL;
            spd_q  <= SPD_FULL;
        end else begin
            spd_s1 <= sw_speed;
            spd_s2 <= spd_s1;
            spd_q  <= spd_s2;
        end
    end

    assign spd_chg = (spd_s2 != spd_q);
    assign div     = spd_div(spd_s2, 32'(DIV1), 32'(DIV2), 32'(DIV3));
    assign at_top  = (pre_cnt == div - 32'd1);
    // A speed change restarts the period, so mask a stale terminal count.
    assign tick    = (spd_s2 == SPD_FULL) || (at_top && !spd_chg);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)                                pre_cnt <= '0;
        else if (state != RUN || spd_chg || at_top) pre_cnt <= '0;
        else                                        pre_cnt <= pre_cnt + 32'd1;
    end

    assign cpu_ce = ce_ok && ((state == RUN && tick) || state == STEP);
    assign halted = cpu_rst_n && (state == HALT);

    logic [31:0] hb_cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt    <= '0;
            heartbeat <= 1'b0;
        end else if (hb_cnt == 32'(HB_DIV - 1)) begin
            hb_cnt    <= '0;
            heartbeat <= ~heartbeat;
        end else begin
            hb_cnt <= hb_cnt + 32'd1;
        end
    end

    logic [31:0] sel;

    always_comb begin
        sel = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (sw_ch == CH_W'(k)) sel = probe_i[32*k +: 32];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) led_o <= '0;
        else        led_o <= LED_W'(sel);
    end

`ifdef CPU_RUN_CYCLE_COUNTER_EN
    logic [31:0] ce_cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)      ce_cnt <= '0;
        else if (cpu_ce) ce_cnt <= ce_cnt + 32'd1;
    end

    assign cycle_cnt = ce_cnt;
`else
    assign cycle_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl with shortened timing parameters.
// Expected gaps/counts queue up at stimulus time and are popped on DUT output.
module tb_cpu_run_ctrl;

    logic        CLOCK_50;
    logic        rst_n;
    logic        key_run_n;
    logic        key_step_n;
    logic [1:0]  sw_speed;
    logic [1:0]  sw_ch;
    logic [95:0] probe_i;
    logic        cpu_ce;
    logic        cpu_rst_n;
    logic        halted;
    logic        heartbeat;
    logic [31:0] cycle_cnt;
    logic [17:0] led_o;

    int checks;
    int failures;
    int exp_q[$];

    typedef struct {
        logic [1:0]  ch;
        logic [95:0] probe;
        logic [17:0] exp;
    } led_vec_t;

    led_vec_t vecs[6];

    cpu_run_ctrl #(
        .DEB_CYCLES   (4),
        .DIV1         (2),
        .DIV2         (4),
        .DIV3         (8),
        .HB_DIV       (16),
        .N_CH         (3),
        .LED_W        (18),
        .RUN_AT_RESET (1)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst_n      (rst_n),
        .key_run_n  (key_run_n),
        .key_step_n (key_step_n),
        .sw_speed   (sw_speed),
        .sw_ch      (sw_ch),
        .probe_i    (probe_i),
        .cpu_ce     (cpu_ce),
        .cpu_rst_n  (cpu_rst_n),
        .halted     (halted),
        .heartbeat  (heartbeat),
        .cycle_cnt  (cycle_cnt),
        .led_o      (led_o)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Cycles until next cpu_ce, or -1 when the budget runs out.
    task automatic wait_ce(input int budget, output int gap);
        gap = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (cpu_ce) begin
                gap = i;
                return;
            end
        end
    endtask

    task automatic count_ce(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (cpu_ce) cnt++;
        end
    endtask

    task automatic check_gaps(input string nm, input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            wait_ce(40, g);
            chk(nm, g, exp_q.pop_front());
        end
    endtask

    task automatic wait_hb_change(input int budget, output int gap);
        logic prev;
        prev = heartbeat;
        gap  = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (heartbeat != prev) begin
                gap = i;
                return;
            end
        end
    endtask

    initial begin
        int g;
        int n;
        logic [17:0] prev_led;
        logic [95:0] p0;
        logic [95:0] p1;

        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        sw_speed   = 2'd0;
        sw_ch      = 2'd0;
        probe_i    = '0;

        p0 = {32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h1234_5678};
        p1 = {32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hAAAA_AAAA};
        vecs[0] = '{2'd2, p0, 18'h1BEEF};
        vecs[1] = '{2'd0, p0, 18'h05678};
        vecs[2] = '{2'd1, p0, 18'h3FFFF};
        vecs[3] = '{2'd3, p0, 18'h00000};
        vecs[4] = '{2'd0, p1, 18'h2AAAA};
        vecs[5] = '{2'd2, p1, 18'h1BEEF};

        // Reset state
        repeat (3) step();
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("rst_cpu_ce", 32'(cpu_ce), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_heartbeat", 32'(heartbeat), 0);
        chk("rst_led", 32'(led_o), 0);
        chk("rst_cycle_cnt", cycle_cnt, 0);

        // Release: cpu_rst_n two cycles later, then free-running ce
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10 && !cpu_rst_n; i++) begin
            step();
            n++;
        end
        chk("cpu_rst_n_delay", n, 2);
        chk("no_ce_at_rst_rise", 32'(cpu_ce), 0);
        wait_ce(10, g);
        chk("first_ce_delay_ok", 32'(g >= 2 && g <= 4), 1);
        chk("run_not_halted", 32'(halted), 0);
        count_ce(10, n);
        chk("full_speed_ce", n, 10);

        // Speed 3 period, then switch to speed 1
        sw_speed = 2'd3;
        repeat (4) step();
        wait_ce(20, g);
        exp_q.push_back(8);
        exp_q.push_back(8);
        check_gaps("speed3_gap", 2);
        sw_speed = 2'd1;
        exp_q.push_back(4);
        exp_q.push_back(2);
        exp_q.push_back(2);
        exp_q.push_back(2);
        check_gaps("speed1_gap", 4);

        // Halt via run key, then one step
        sw_speed = 2'd0;
        repeat (4) step();
        key_run_n = 1'b0;
        repeat (10) step();
        key_run_n = 1'b1;
        repeat (10) step();
        chk("halt_after_run_key", 32'(halted), 1);
        count_ce(8, n);
        chk("halt_no_ce", n, 0);
        key_step_n = 1'b0;
        exp_q.push_back(1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 6) key_step_n = 1'b1;
            step();
            if (cpu_ce) n++;
        end
        chk("step_ce_count", n, exp_q.pop_front());
        chk("halt_after_step", 32'(halted), 1);

        // Bounce shorter than debounce window is ignored
        for (int i = 0; i < 6; i++) begin
            key_run_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key_run_n = 1'b1;
        count_ce(12, n);
        chk("bounce_no_ce", n, 0);
        chk("bounce_still_halted", 32'(halted), 1);

        // Run and step together from HALT: run wins
        key_run_n  = 1'b0;
        key_step_n = 1'b0;
        repeat (8) step();
        key_run_n  = 1'b1;
        key_step_n = 1'b1;
        repeat (12) step();
        chk("run_step_run_wins", 32'(halted), 0);

        // LED probe table with one-cycle latency
        prev_led = 18'h0;
        foreach (vecs[i]) begin
            sw_ch   = vecs[i].ch;
            probe_i = vecs[i].probe;
            #1;
            chk($sformatf("led_hold_%0d", i), 32'(led_o), 32'(prev_led));
            step();
            chk($sformatf("led_vec_%0d", i), 32'(led_o), 32'(vecs[i].exp));
            prev_led = vecs[i].exp;
        end

        // Heartbeat half-period
        wait_hb_change(40, g);
        exp_q.push_back(16);
        exp_q.push_back(16);
        for (int i = 0; i < 2; i++) begin
            wait_hb_change(40, g);
            chk("hb_half_period", g, exp_q.pop_front());
        end

        // Cycle counter over 100 pulses, then reset mid-run
        rst_n    = 1'b0;
        sw_speed = 2'd2;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_ce(20, g);
            if (g < 0) begin
                chk("ce_for_counter", g, 4);
                break;
            end
        end
        step();
        chk("ce_low_after_pulse", 32'(cpu_ce), 0);
`ifdef CPU_RUN_CYCLE_COUNTER_EN
        chk("cycle_cnt_100", cycle_cnt, 100);
`else
        chk("cycle_cnt_tied", cycle_cnt, 0);
`endif
        sw_speed = 2'd0;
        repeat (5) step();
        chk("ce_before_midrun_rst", 32'(cpu_ce), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_ce", 32'(cpu_ce), 0);
        chk("midrun_rst_cpu_rst_n", 32'(cpu_rst_n), 0);
        chk("midrun_rst_cycle_cnt", cycle_cnt, 0);
        chk("midrun_rst_led", 32'(led_o), 0);
        count_ce(3, n);
        chk("midrun_rst_no_trailing_ce", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
